// File: rtl/inst_sequencer.sv
// Instruction store plus run/step/halt sequencer for a simple CPU. The host
// loads the store while the CPU is stopped; the sequencer gates CPU advance.
module inst_sequencer #(
  parameter int DEPTH  = 16,
  parameter int INST_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [3:0]        host_addr,
  input  logic [INST_W-1:0] host_data,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic              bp_en,
  input  logic [3:0]        bp_addr,
  input  logic [3:0]        pc,
  output logic [INST_W-1:0] inst,
  output logic              cpu_en,
  output logic              bp_hit,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              skip_bp;
  logic              bp_match;
  logic              wr_en;
  logic [INST_W-1:0] store [DEPTH];

  // Host handshake: a write transfers on any rising edge where host_valid and
  // host_ready are both high; host_ready depends only on the current state.
  assign host_ready = (state_q == IDLE) || (state_q == HALT);
  assign wr_en      = host_valid && host_ready;
  assign inst       = store[pc];
  assign state      = state_q;
  assign bp_match   = bp_en && (pc == bp_addr) && !skip_bp;

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (wr_en) begin
      store[host_addr] <= host_data;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cpu_en  = 1'b0;
    bp_hit  = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (cmd_halt)      state_d = HALT;
        else if (cmd_step) state_d = STEP;
        else if (cmd_run)  state_d = RUN;
      end
      RUN: begin
        // A breakpoint blocks the instruction at pc in the same cycle.
        if (bp_match) begin
          bp_hit  = 1'b1;
          state_d = HALT;
        end else begin
          cpu_en = 1'b1;
          if (cmd_halt) state_d = HALT;
        end
      end
      STEP: begin
        cpu_en  = 1'b1;
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Resuming from HALT must execute the instruction we stopped on.
  always_ff @(posedge clk_cpu) begin
    if (reset)                                     skip_bp <= 1'b0;
    else if (state_q == HALT && state_d == RUN)    skip_bp <= 1'b1;
    else if (state_q == RUN)                       skip_bp <= 1'b0;
  end

  always_ff @(posedge clk_cpu) begin
    if (reset)
      cycle_cnt <= '0;
    else if (cpu_en && (cycle_cnt != {CNT_W{1'b1}}))
      cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: store load/readback via an expected
// queue, run/halt, breakpoints, stepping, priority, saturation and reset.
`timescale 1ns/1ps
module tb_inst_sequencer;

  logic       clk_cpu = 1'b0;
  logic       reset;
  logic       host_valid;
  logic [3:0] host_addr;
  logic [7:0] host_data;
  logic       cmd_run, cmd_step, cmd_halt;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic [3:0] pc;

  logic       host_ready, cpu_en, bp_hit;
  logic [7:0] inst;
  logic [1:0] state;
  logic [7:0] cycle_cnt;

  logic       host_ready_s, cpu_en_s, bp_hit_s;
  logic [7:0] inst_s;
  logic [1:0] state_s;
  logic [3:0] cycle_cnt_s;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mem_model[16];

  always #5 clk_cpu = ~clk_cpu;

  inst_sequencer dut (
    .clk_cpu(clk_cpu), .reset(reset), .host_valid(host_valid),
    .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .inst(inst),
    .cpu_en(cpu_en), .bp_hit(bp_hit), .state(state), .cycle_cnt(cycle_cnt)
  );

  inst_sequencer #(.CNT_W(4)) dut_sat (
    .clk_cpu(clk_cpu), .reset(reset), .host_valid(host_valid),
    .host_ready(host_ready_s), .host_addr(host_addr), .host_data(host_data),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .inst(inst_s),
    .cpu_en(cpu_en_s), .bp_hit(bp_hit_s), .state(state_s),
    .cycle_cnt(cycle_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_cpu);
    #1;
  endtask

  // Advance one edge and move pc like a CPU would when cpu_en was high.
  task automatic cpu_cyc();
    logic adv;
    adv = cpu_en;
    cyc();
    if (adv) pc = pc + 4'd1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    check("host_ready_wr", {31'd0, host_ready}, 32'd1);
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    cyc();
    host_valid = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic probe_inst(input logic [3:0] p);
    pc = p;
    exp_q.push_back(mem_model[p]);
    #1;
    check($sformatf("inst[%0d]", p), {24'd0, inst}, {24'd0, exp_q.pop_front()});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_addr = '0; host_data = '0;
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    bp_en = 1'b0; bp_addr = '0; pc = '0;
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
    #1;

    check("rst_state",  {30'd0, state}, 32'd0);
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("rst_cnt",    {24'd0, cycle_cnt}, 32'd0);
    check("rst_ready",  {31'd0, host_ready}, 32'd1);
    for (int i = 0; i < 16; i++) begin probe_inst(4'(i)); cyc(); end

    // Load
    host_write(4'd0, 8'h31);
    host_write(4'd1, 8'h52);
    probe_inst(4'd1);
    probe_inst(4'd0);
    for (int i = 2; i < 16; i++) host_write(4'(i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) begin probe_inst(4'(i)); cyc(); end
    check("load_ready", {31'd0, host_ready}, 32'd1);

    // Run / halt, run and step ignored while running
    pc = 4'd0;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0; #1;
    check("run_state",  {30'd0, state}, 32'd1);
    check("run_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("run_ready",  {31'd0, host_ready}, 32'd0);
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0; cmd_run = 1'b1; #1;
    check("run_ign_step", {30'd0, state}, 32'd1);
    cyc(); cmd_run = 1'b0; #1;
    check("run_ign_run", {30'd0, state}, 32'd1);
    cyc(); cyc();
    cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0; #1;
    check("halt_state",  {30'd0, state}, 32'd3);
    check("halt_cnt",    {24'd0, cycle_cnt}, 32'd5);
    check("halt_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("halt_ready",  {31'd0, host_ready}, 32'd1);

    // Breakpoint at pc 3
    pc = 4'd0; bp_en = 1'b1; bp_addr = 4'd3;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0; #1;
    check("bp_run_en", {31'd0, cpu_en}, 32'd1);
    cpu_cyc(); cpu_cyc(); cpu_cyc();
    check("bp_pc",     {28'd0, pc}, 32'd3);
    check("bp_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("bp_hit",    {31'd0, bp_hit}, 32'd1);
    cyc(); #1;
    check("bp_state",  {30'd0, state}, 32'd3);
    check("bp_hit_1cy", {31'd0, bp_hit}, 32'd0);
    check("bp_cnt",    {24'd0, cycle_cnt}, 32'd8);
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0; #1;
    check("resume_en",  {31'd0, cpu_en}, 32'd1);
    check("resume_nohit", {31'd0, bp_hit}, 32'd0);
    cpu_cyc();
    check("resume_state", {30'd0, state}, 32'd1);
    check("resume_pc4",   {31'd0, cpu_en}, 32'd1);
    cmd_halt = 1'b1; cpu_cyc(); cmd_halt = 1'b0; #1;
    check("resume_halt", {30'd0, state}, 32'd3);
    check("resume_cnt",  {24'd0, cycle_cnt}, 32'd10);

    // Halt command coinciding with a breakpoint match
    bp_addr = 4'd6;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0; #1;
    cpu_cyc();
    cmd_halt = 1'b1; #1;
    check("bph_hit",    {31'd0, bp_hit}, 32'd1);
    check("bph_cpu_en", {31'd0, cpu_en}, 32'd0);
    cyc(); cmd_halt = 1'b0; #1;
    check("bph_state", {30'd0, state}, 32'd3);
    check("bph_cnt",   {24'd0, cycle_cnt}, 32'd11);

    // Step onto the breakpoint pc; run during STEP is ignored
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0; #1;
    check("step_state",  {30'd0, state}, 32'd2);
    check("step_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("step_nohit",  {31'd0, bp_hit}, 32'd0);
    cmd_run = 1'b1; cpu_cyc(); cmd_run = 1'b0; #1;
    check("step_done", {30'd0, state}, 32'd3);
    check("step_off",  {31'd0, cpu_en}, 32'd0);
    check("step_cnt",  {24'd0, cycle_cnt}, 32'd12);
    cyc(); #1;
    check("step_once", {24'd0, cycle_cnt}, 32'd12);

    // Host write accepted in the same cycle as a step command
    host_valid = 1'b1; host_addr = pc; host_data = 8'hA5; cmd_step = 1'b1;
    cyc();
    host_valid = 1'b0; cmd_step = 1'b0; mem_model[pc] = 8'hA5; #1;
    check("wrstep_state", {30'd0, state}, 32'd2);
    probe_inst(pc);
    cyc(); #1;
    check("wrstep_cnt", {24'd0, cycle_cnt}, 32'd13);

    // Priority: run + halt together in IDLE; step beats run in HALT
    bp_en = 1'b0;
    do_reset();
    check("pri_rst_state", {30'd0, state}, 32'd0);
    check("pri_rst_cnt",   {24'd0, cycle_cnt}, 32'd0);
    cmd_run = 1'b1; cmd_halt = 1'b1; cyc(); cmd_run = 1'b0; cmd_halt = 1'b0; #1;
    check("pri_halt", {30'd0, state}, 32'd3);
    cmd_run = 1'b1; cmd_step = 1'b1; cyc(); cmd_run = 1'b0; cmd_step = 1'b0; #1;
    check("pri_step", {30'd0, state}, 32'd2);

    // Saturation and reset mid-RUN
    do_reset();
    for (int i = 0; i < 4; i++) host_write(4'(i * 3 + 1), 8'($urandom_range(1, 255)));
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    repeat (20) cyc();
    #1;
    check("sat_cnt4",   {28'd0, cycle_cnt_s}, 32'd15);
    check("sat_cnt8",   {24'd0, cycle_cnt}, 32'd20);
    check("sat_state",  {30'd0, state_s}, 32'd1);
    check("sat_cpu_en", {31'd0, cpu_en_s}, 32'd1);
    do_reset();
    check("mid_state",  {30'd0, state}, 32'd0);
    check("mid_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("mid_cnt",    {24'd0, cycle_cnt}, 32'd0);
    check("mid_cnt4",   {28'd0, cycle_cnt_s}, 32'd0);
    check("mid_ready",  {31'd0, host_ready}, 32'd1);
    for (int i = 0; i < 16; i++) begin probe_inst(4'(i)); cyc(); end
    check("sb_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
